// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-stage controller: FSM states, default widths,
// and the write-buffer entry layout.
package mem_stage_pkg;

  localparam int unsigned AW_DEFAULT = 32;
  localparam int unsigned DW_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WDRAIN = 2'd1,
    RREQ   = 2'd2,
    RDONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [AW_DEFAULT-1:0] addr;
    logic [DW_DEFAULT-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Write-buffer FIFO; a push is still accepted when full if a pop happens in
// the same cycle.
module wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [W-1:0]           head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    do_push = push && (!full || pop);
    do_pop  = pop && !empty;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + PW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + PW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: posts stores into a write buffer, drains it to the
// external memory, and serialises loads behind pending stores.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned WB_DEPTH = 2,
  parameter int unsigned AW       = AW_DEFAULT,
  parameter int unsigned DW       = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memreadm,
  input  logic          memwritem,
  input  logic [AW-1:0] addrm,
  input  logic [DW-1:0] wdatam,
  output logic [DW-1:0] rdatam,
  output logic          memready,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata
);

  localparam int unsigned EW = AW + DW;
  localparam int unsigned CW = $clog2(WB_DEPTH) + 1;

  state_e        state_q, state_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          push, drain_ack, full, empty;
  logic [CW-1:0] count;
  logic [EW-1:0] head;

  // A simultaneous load request wins; the store is dropped.
  assign drain_ack = (state_q == WDRAIN) && bus_ack;
  assign push      = memwritem && !memreadm && (!full || drain_ack);
  assign rdatam    = rdata_q;

  wb_fifo #(
    .DEPTH(WB_DEPTH),
    .W    (EW)
  ) u_wb_fifo (
    .clk  (clk),
    .rst_n(reset),
    .push (push),
    .pop  (drain_ack),
    .din  ({addrm, wdatam}),
    .full (full),
    .empty(empty),
    .count(count),
    .head (head)
  );

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = WDRAIN;
        end else if (memreadm) begin
          state_d = RREQ;
        end
      end
      WDRAIN: begin
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = head[EW-1 -: AW];
        bus_wdata = head[DW-1:0];
        if (bus_ack) begin
          if (count > CW'(1) || push) begin
            state_d = WDRAIN;
          end else if (memreadm) begin
            state_d = RREQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RREQ: begin
        bus_req  = 1'b1;
        bus_addr = addrm;
        if (bus_ack) begin
          rdata_d = bus_rdata;
          state_d = RDONE;
        end
      end
      RDONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Stall policy seen by the pipeline.
    if (memreadm) begin
      memready = (state_q == RDONE);
    end else if (memwritem) begin
      memready = push;
    end else begin
      memready = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
